// File: rtl/modulo_counter.sv
// Up/down modulo counter with wrap or clamp at the range ends; optional parallel
// load is compiled in when MODULO_COUNTER_LOAD_EN is defined.
module modulo_counter #(
   parameter int W        = 8,
   parameter int MOD      = 256,
   parameter bit SATURATE = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [1:0]   control,
   input  logic [W-1:0] step,
`ifdef MODULO_COUNTER_LOAD_EN
   input  logic         load,
   input  logic [W-1:0] load_val,
`endif
   output logic [W-1:0] count,
   output logic         wrap_up,
   output logic         wrap_dn,
   output logic         at_max,
   output logic         at_zero
);

   // One extra bit so MOD itself and count+step never overflow.
   localparam logic [W:0] MOD_C = (W+1)'(MOD);
   localparam logic [W:0] TOP_C = (W+1)'(MOD - 1);

   logic [W-1:0] count_q, count_d;
   logic         wrap_up_q, wrap_up_d;
   logic         wrap_dn_q, wrap_dn_d;

   logic [W:0]   cnt_ext;
   logic [W:0]   step_ext;
   logic [W:0]   s_eff;
   logic [W:0]   sum;
   logic [W:0]   next_ext;
   logic         load_eff;
   logic [W:0]   load_ext;

`ifdef MODULO_COUNTER_LOAD_EN
   assign load_eff = load;
   assign load_ext = {1'b0, load_val};
`else
   assign load_eff = 1'b0;
   assign load_ext = '0;
`endif

   assign cnt_ext  = {1'b0, count_q};
   assign step_ext = {1'b0, step};
   assign s_eff    = (step_ext > TOP_C) ? TOP_C : step_ext;
   assign sum      = cnt_ext + s_eff;

   always_comb begin
      next_ext  = cnt_ext;
      wrap_up_d = 1'b0;
      wrap_dn_d = 1'b0;
      if (clr) begin
         next_ext = '0;
      end else if (load_eff) begin
         next_ext = (load_ext > TOP_C) ? TOP_C : load_ext;
      end else if (control == 2'b01 && s_eff != '0) begin
         if (sum > TOP_C) begin
            wrap_up_d = 1'b1;
            next_ext  = SATURATE ? TOP_C : (sum - MOD_C);
         end else begin
            next_ext  = sum;
         end
      end else if (control == 2'b10 && s_eff != '0) begin
         // In wrap mode count+MOD-s stays below MOD because s > count here.
         if (s_eff > cnt_ext) begin
            wrap_dn_d = 1'b1;
            next_ext  = SATURATE ? '0 : (cnt_ext + MOD_C - s_eff);
         end else begin
            next_ext  = cnt_ext - s_eff;
         end
      end
      count_d = next_ext[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         wrap_up_q <= 1'b0;
         wrap_dn_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrap_up_q <= wrap_up_d;
         wrap_dn_q <= wrap_dn_d;
      end
   end

   assign count   = count_q;
   assign wrap_up = wrap_up_q;
   assign wrap_dn = wrap_dn_q;
   assign at_max  = (cnt_ext == TOP_C);
   assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_modulo_counter.sv
// Bench for modulo_counter: four configurations share one stimulus stream and are
// checked every cycle against an integer model, plus literal scenario checks.
module tb_modulo_counter;

`ifdef MODULO_COUNTER_LOAD_EN
   localparam bit LOAD_EN = 1'b1;
`else
   localparam bit LOAD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clr, load;
   logic [1:0] control;
   logic [7:0] step, load_val;

   logic [7:0] c_wrap, c_sat, c_full;
   logic [3:0] c_w4;
   logic [3:0] up_v, dn_v, mx_v, zr_v;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // instance 0: W8 MOD10 wrap, 1: W8 MOD10 clamp, 2: W4 MOD16 wrap, 3: W8 MOD256 wrap
   modulo_counter #(.W(8), .MOD(10), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .clr(clr), .control(control), .step(step),
`ifdef MODULO_COUNTER_LOAD_EN
      .load(load), .load_val(load_val),
`endif
      .count(c_wrap), .wrap_up(up_v[0]), .wrap_dn(dn_v[0]), .at_max(mx_v[0]), .at_zero(zr_v[0]));

   modulo_counter #(.W(8), .MOD(10), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .clr(clr), .control(control), .step(step),
`ifdef MODULO_COUNTER_LOAD_EN
      .load(load), .load_val(load_val),
`endif
      .count(c_sat), .wrap_up(up_v[1]), .wrap_dn(dn_v[1]), .at_max(mx_v[1]), .at_zero(zr_v[1]));

   modulo_counter #(.W(4), .MOD(16), .SATURATE(1'b0)) u_w4 (
      .clk(clk), .rst(rst), .clr(clr), .control(control), .step(step[3:0]),
`ifdef MODULO_COUNTER_LOAD_EN
      .load(load), .load_val(load_val[3:0]),
`endif
      .count(c_w4), .wrap_up(up_v[2]), .wrap_dn(dn_v[2]), .at_max(mx_v[2]), .at_zero(zr_v[2]));

   modulo_counter #(.W(8), .MOD(256), .SATURATE(1'b0)) u_full (
      .clk(clk), .rst(rst), .clr(clr), .control(control), .step(step),
`ifdef MODULO_COUNTER_LOAD_EN
      .load(load), .load_val(load_val),
`endif
      .count(c_full), .wrap_up(up_v[3]), .wrap_dn(dn_v[3]), .at_max(mx_v[3]), .at_zero(zr_v[3]));

   function automatic int mod_of(input int i);
      case (i)
         0, 1:    return 10;
         2:       return 16;
         default: return 256;
      endcase
   endfunction

   function automatic logic [31:0] cnt_of(input int i);
      case (i)
         0:       return {24'b0, c_wrap};
         1:       return {24'b0, c_sat};
         2:       return {28'b0, c_w4};
         default: return {24'b0, c_full};
      endcase
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got=%0d expected=%0d at t=%0t", nm, idx, act, exp, $time);
      end
   endtask

   // Integer reference: the counter's rules applied directly to a number in 0..MOD-1.
   int mc[4], mu[4], md[4];

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         int m, st, lv, s;
         m  = mod_of(i);
         st = (i == 2) ? int'(step[3:0]) : int'(step);
         lv = (i == 2) ? int'(load_val[3:0]) : int'(load_val);
         s  = (st > m - 1) ? m - 1 : st;
         mu[i] = 0;
         md[i] = 0;
         if (rst || clr) begin
            mc[i] = 0;
         end else if (LOAD_EN && load) begin
            mc[i] = (lv > m - 1) ? m - 1 : lv;
         end else if (control == 2'b01 && s > 0) begin
            if (mc[i] + s > m - 1) begin
               mu[i] = 1;
               mc[i] = (i == 1) ? m - 1 : mc[i] + s - m;
            end else begin
               mc[i] = mc[i] + s;
            end
         end else if (control == 2'b10 && s > 0) begin
            if (s > mc[i]) begin
               md[i] = 1;
               mc[i] = (i == 1) ? 0 : mc[i] + m - s;
            end else begin
               mc[i] = mc[i] - s;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 4; i++) begin
            chk("count",   i, cnt_of(i),       mc[i]);
            chk("wrap_up", i, {31'b0, up_v[i]}, mu[i]);
            chk("wrap_dn", i, {31'b0, dn_v[i]}, md[i]);
            chk("at_max",  i, {31'b0, mx_v[i]}, int'(mc[i] == mod_of(i) - 1));
            chk("at_zero", i, {31'b0, zr_v[i]}, int'(mc[i] == 0));
         end
      end
   end

   task automatic cyc(input logic r, input logic c, input logic l, input logic [7:0] lv,
                      input logic [1:0] ctl, input logic [7:0] stp);
      rst = r; clr = c; load = l; load_val = lv; control = ctl; step = stp;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; control = 2'b00; step = '0;
      cyc(1, 0, 0, 0, 2'b01, 8'd3);
      chk_en = 1'b1;
      chk("lit_rst_count", 0, cnt_of(0), 0);
      chk("lit_rst_zero",  0, {31'b0, zr_v[0]}, 1);
      chk("lit_rst_max",   0, {31'b0, mx_v[0]}, 0);

      // wrap up: 7 + 5 mod 10
      cyc(0, 1, 0, 0, 2'b00, 0);
      cyc(0, 0, 0, 0, 2'b01, 8'd7);
      cyc(0, 0, 0, 0, 2'b01, 8'd5);
      chk("lit_wrap_up_cnt", 0, cnt_of(0), 2);
      chk("lit_wrap_up",     0, {31'b0, up_v[0]}, 1);
      cyc(0, 0, 0, 0, 2'b00, 8'd5);
      chk("lit_wrap_up_drop", 0, {31'b0, up_v[0]}, 0);

      // wrap down: 1 - 3 mod 10, then hold
      cyc(0, 1, 0, 0, 2'b00, 0);
      cyc(0, 0, 0, 0, 2'b01, 8'd1);
      cyc(0, 0, 0, 0, 2'b10, 8'd3);
      chk("lit_wrap_dn_cnt", 0, cnt_of(0), 8);
      chk("lit_wrap_dn",     0, {31'b0, dn_v[0]}, 1);
      cyc(0, 0, 0, 0, 2'b00, 8'd3);
      chk("lit_hold_cnt",    0, cnt_of(0), 8);
      chk("lit_hold_dn",     0, {31'b0, dn_v[0]}, 0);

      // clamp at top, repeated pulses
      cyc(0, 1, 0, 0, 2'b00, 0);
      cyc(0, 0, 0, 0, 2'b01, 8'd9);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 2'b01, 8'd1);
         chk("lit_clamp_cnt", 1, cnt_of(1), 9);
         chk("lit_clamp_up",  1, {31'b0, up_v[1]}, 1);
         chk("lit_clamp_max", 1, {31'b0, mx_v[1]}, 1);
      end

      // clamp at zero, repeated pulses
      cyc(0, 1, 0, 0, 2'b00, 0);
      for (int k = 0; k < 2; k++) begin
         cyc(0, 0, 0, 0, 2'b10, 8'd1);
         chk("lit_clamp0_cnt", 1, cnt_of(1), 0);
         chk("lit_clamp0_dn",  1, {31'b0, dn_v[1]}, 1);
      end

      // clr beats load and control; oversize load clamps to MOD-1
      cyc(0, 1, 1, 8'd4, 2'b01, 8'd2);
      chk("lit_clr_prio", 0, cnt_of(0), 0);
      if (LOAD_EN) begin
         cyc(0, 0, 1, 8'd200, 2'b01, 8'd2);
         chk("lit_load_clamp", 0, cnt_of(0), 9);
      end

      // reset beats an INC, including one that would wrap
      cyc(0, 1, 0, 0, 2'b00, 0);
      cyc(0, 0, 0, 0, 2'b01, 8'd5);
      cyc(1, 0, 0, 0, 2'b01, 8'd3);
      chk("lit_rst_inc_cnt",  0, cnt_of(0), 0);
      chk("lit_rst_inc_zero", 0, {31'b0, zr_v[0]}, 1);
      cyc(0, 0, 0, 0, 2'b01, 8'd5);
      cyc(1, 0, 0, 0, 2'b01, 8'd7);
      chk("lit_rst_wrap_up", 0, {31'b0, up_v[0]}, 0);

      // W4 wrap with full step; step clamping at MOD=10
      cyc(0, 1, 0, 0, 2'b00, 0);
      cyc(0, 0, 0, 0, 2'b01, 8'd15);
      cyc(0, 0, 0, 0, 2'b01, 8'd15);
      chk("lit_w4_cnt", 2, cnt_of(2), 14);
      chk("lit_w4_up",  2, {31'b0, up_v[2]}, 1);
      cyc(0, 1, 0, 0, 2'b00, 0);
      cyc(0, 0, 0, 0, 2'b01, 8'd12);
      chk("lit_step_clamp_cnt", 0, cnt_of(0), 9);
      chk("lit_step_clamp_up",  0, {31'b0, up_v[0]}, 0);

      for (int n = 0; n < 1500; n++) begin
         logic       r, c, l;
         logic [7:0] stp;
         r   = ($urandom_range(63) == 0);
         c   = ($urandom_range(15) == 0);
         l   = ($urandom_range(7) == 0);
         stp = ($urandom_range(1) == 0) ? 8'($urandom_range(12)) : 8'($urandom);
         cyc(r, c, l, 8'($urandom), 2'($urandom), stp);
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
